// File: rtl/pll_reset_seq.sv
// rtl/pll_reset_seq.sv - PLL lock supervisor with staggered per-domain reset release
module pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_RST        = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER        = 4,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int PLL_RST_CYCLES = 8,
    parameter int CNT_W          = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_locked,
    output logic               o_pll_rst,
    output logic [NUM_RST-1:0] o_rst,
    output logic               o_ready,
    output logic [CNT_W-1:0]   o_lock_lost
);
    localparam int REL_CYCLES = (NUM_RST - 1) * STAGGER;
    localparam int MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD     = (HOLD_CYCLES > REL_CYCLES) ? HOLD_CYCLES : REL_CYCLES;
    localparam int MAX_CNT    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW         = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_HOLD      = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   slock;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_RST-1:0]     rst_q, rst_d;
    logic                   ready_q, ready_d;
    logic [CNT_W-1:0]       lost_q, lost_d;

    assign slock       = sync_q[SYNC_STAGES-1];
    assign o_pll_rst   = pll_rst_q;
    assign o_rst       = rst_q;
    assign o_ready     = ready_q;
    assign o_lock_lost = lost_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], i_locked};
            pll_rst_q <= pll_rst_d;
            rst_q     <= rst_d;
            ready_q   <= ready_d;
            lost_q    <= lost_d;
        end
    end

    // One shared counter: its meaning depends on the state it is used in.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (slock) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (!slock) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = (NUM_RST == 1) ? S_RUN : S_RELEASE;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (!slock) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(REL_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!slock) begin
                    state_d = S_PLL_RST;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decode the next state so every output comes straight from a flop.
    always_comb begin
        pll_rst_d = (state_d == S_PLL_RST);
        ready_d   = (state_d == S_RUN);
        for (int k = 0; k < NUM_RST; k++) begin
            rst_d[k] = !((state_d == S_RUN) ||
                         ((state_d == S_RELEASE) && (int'(cnt_d) >= k * STAGGER)));
        end
        lost_d = lost_q;
        if ((state_q == S_RUN) && !slock && (lost_q != {CNT_W{1'b1}})) begin
            lost_d = lost_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb/tb_pll_reset_seq.sv - scoreboard bench for pll_reset_seq
module tb_pll_reset_seq;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_locked = 1'b0;
    logic       o_pll_rst, o_ready;
    logic [3:0] o_rst;
    logic [7:0] o_lock_lost;
    logic       o_pll_rst2, o_ready2;
    logic [3:0] o_rst2;
    logic [1:0] o_lock_lost2;
    logic       o_pll_rst1, o_ready1;
    logic [0:0] o_rst1;
    logic [7:0] o_lock_lost1;
    logic [17:0] obs;

    typedef struct {
        int          cyc;
        logic [17:0] v;
    } exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    always #5 i_clk = ~i_clk;

    pll_reset_seq dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_locked(i_locked),
        .o_pll_rst(o_pll_rst), .o_rst(o_rst), .o_ready(o_ready), .o_lock_lost(o_lock_lost)
    );
    pll_reset_seq #(.CNT_W(2)) dut_w2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_locked(i_locked),
        .o_pll_rst(o_pll_rst2), .o_rst(o_rst2), .o_ready(o_ready2), .o_lock_lost(o_lock_lost2)
    );
    pll_reset_seq #(.NUM_RST(1)) dut_n1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_locked(i_locked),
        .o_pll_rst(o_pll_rst1), .o_rst(o_rst1), .o_ready(o_ready1), .o_lock_lost(o_lock_lost1)
    );

    assign obs = {o_pll_rst, o_rst, o_ready, o_lock_lost, o_lock_lost2, o_rst1[0], o_ready1};

    // Expected vector; the 2-bit counter copy saturates at 3.
    function automatic logic [17:0] mk(logic pll, logic [3:0] rst, logic rdy,
                                       logic [7:0] lost, logic n1run);
        logic [1:0] l2;
        l2 = (lost > 8'd3) ? 2'd3 : lost[1:0];
        return {pll, rst, rdy, lost, l2, ~n1run, n1run};
    endfunction

    // Staggered release schedule with o_rst[0] dropping at cycle t.
    function automatic logic [3:0] rel(int r, int t);
        if (r < t)           return 4'hF;
        else if (r < t + 4)  return 4'hE;
        else if (r < t + 8)  return 4'hC;
        else if (r < t + 12) return 4'h8;
        else                 return 4'h0;
    endfunction

    task automatic test_reset();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 3; r++) sb.push_back('{r, mk(1'b1, 4'hF, 1'b0, 8'd0, 1'b0)});
        for (int r = 0; r <= 3; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL reset r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
        end
    endtask

    task automatic test_no_lock();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 1045; r++)
            sb.push_back('{r, mk((r < 8) || (r >= 1032 && r < 1040), 4'hF, 1'b0, 8'd0, 1'b0)});
        for (int r = 0; r <= 1045; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL no_lock r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
        end
    endtask

    // Lock at cycle 10: slock lands 2 cycles later, HOLD takes 16, release 19 after the edge.
    task automatic test_release();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 50; r++)
            sb.push_back('{r, mk(r < 8, rel(r, 29), r >= 41, 8'd0, r >= 29)});
        for (int r = 0; r <= 50; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL release r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r == 10) i_locked = 1'b1;
        end
    endtask

    task automatic test_hold_glitch();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 60; r++)
            sb.push_back('{r, mk(r < 8, rel(r, 41), r >= 53, 8'd0, r >= 41)});
        for (int r = 0; r <= 60; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL hold_glitch r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r == 10) i_locked = 1'b1;
            if (r == 21) i_locked = 1'b0;
            if (r == 22) i_locked = 1'b1;
        end
    endtask

    task automatic test_release_drop();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 40; r++)
            sb.push_back('{r, mk(r < 8, (r >= 33) ? 4'hF : rel(r, 29), 1'b0, 8'd0,
                                 (r >= 29) && (r < 33))});
        for (int r = 0; r <= 40; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL release_drop r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r == 10) i_locked = 1'b1;
            if (r == 30) i_locked = 1'b0;
        end
    endtask

    task automatic test_run_loss();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 70; r++) begin
            if (r < 53) sb.push_back('{r, mk(r < 8, rel(r, 29), r >= 41, 8'd0, r >= 29)});
            else        sb.push_back('{r, mk(r < 61, 4'hF, 1'b0, 8'd1, 1'b0)});
        end
        for (int r = 0; r <= 70; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL run_loss r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r == 10) i_locked = 1'b1;
            if (r == 50) i_locked = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        for (int r = 0; r <= 80; r++) begin
            if (r < 35) sb.push_back('{r, mk(r < 8, rel(r, 29), 1'b0, 8'd0, r >= 29)});
            else        sb.push_back('{r, mk(r < 43, rel(r, 60), r >= 72, 8'd0, r >= 60)});
        end
        for (int r = 0; r <= 80; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL reset_mid r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r == 10) i_locked = 1'b1;
            if (r == 34) i_rst = 1'b1;
            if (r == 35) i_rst = 1'b0;
        end
    endtask

    // Five RUN losses 60 cycles apart; 8-bit count reaches 5, 2-bit copy sticks at 3.
    task automatic test_saturation();
        exp_t e;
        i_rst = 1'b1;
        i_locked = 1'b0;
        sb.push_back('{0, mk(1'b1, 4'hF, 1'b0, 8'd0, 1'b0)});
        for (int i = 0; i < 5; i++)
            sb.push_back('{65 + 60 * i, mk(1'b0, 4'hF, 1'b0, 8'(i + 1), 1'b0)});
        for (int r = 0; r <= 305; r++) begin
            @(posedge i_clk); #1;
            while (sb.size() > 0 && sb[0].cyc == r) begin
                e = sb.pop_front(); total++;
                if (obs !== e.v) begin bad++; $display("FAIL saturation r=%0d got=%h want=%h", r, obs, e.v); end
            end
            if (r == 0) i_rst = 1'b0;
            if (r >= 10 && r < 300 && (r - 10) % 60 == 0) i_locked = 1'b1;
            if (r >= 50 && (r - 50) % 60 == 0) i_locked = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_no_lock();
        test_release();
        test_hold_glitch();
        test_release_drop();
        test_run_loss();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchroniser depth for i_locked (minimum 2).
REQ-002 Parameter NUM_RST, default 4, sets the number of sequenced reset outputs (minimum 1).
REQ-003 Parameter HOLD_CYCLES, default 16, sets the consecutive synchronised-lock cycles required before release (minimum 1).
REQ-004 Parameter STAGGER, default 4, sets the cycles between successive o_rst bit releases (minimum 1).
REQ-005 Parameter LOCK_TIMEOUT, default 1024, sets the cycles allowed in WAIT_LOCK before the PLL is reset again.
REQ-006 Parameter PLL_RST_CYCLES, default 8, sets the o_pll_rst pulse length (minimum 1).
REQ-007 Parameter CNT_W, default 8, sets the width of the lock-loss counter.
REQ-008 i_clk  input  1  sole clock; all logic is on its rising edge.
REQ-009 i_rst  input  1  synchronous, active-high reset.
REQ-010 i_locked  input  1  PLL lock, asynchronous to i_clk.
REQ-011 o_pll_rst  output  1  reset request to the PLL.
REQ-012 o_rst  output  NUM_RST  per-domain reset, active-high; bit k is released k-th.
REQ-013 o_ready  output  1  high when all of o_rst are released and the block is in RUN.
REQ-014 o_lock_lost  output  CNT_W  count of lock losses seen in RUN.

Function
REQ-015 i_locked shall pass through a SYNC_STAGES flop chain; the output "slock" is the only lock signal used internally.
REQ-016 The FSM shall have states PLL_RST, WAIT_LOCK, HOLD, RELEASE and RUN.
REQ-017 PLL_RST: o_pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-018 WAIT_LOCK: o_pll_rst=0; if slock=1, go to HOLD; if LOCK_TIMEOUT cycles elapse without slock, go to PLL_RST.
REQ-019 HOLD: count consecutive slock=1 cycles; on reaching HOLD_CYCLES, go to RELEASE; if slock=0, go to WAIT_LOCK with the timeout counter cleared.
REQ-020 RELEASE: o_rst[0] shall deassert on the first RELEASE cycle and o_rst[k] exactly k*STAGGER cycles after o_rst[0].
REQ-021 The FSM shall enter RUN in the same cycle o_rst[NUM_RST-1] deasserts; o_ready=1 only in RUN.
REQ-022 slock=0 in RELEASE: all o_rst bits shall reassert on the next cycle, the FSM goes to WAIT_LOCK, and o_lock_lost is unchanged.
REQ-023 slock=0 in RUN: on the next cycle all o_rst bits reassert, o_ready=0, o_lock_lost increments, and the FSM goes to PLL_RST.
REQ-024 o_lock_lost shall saturate at all-ones and never wrap.
REQ-025 o_rst bits shall be all 1 in every state except RELEASE and RUN.
REQ-026 Once released, an o_rst bit shall not reassert except under REQ-022, REQ-023 or i_rst.
REQ-027 All outputs shall be registered and glitch-free.
REQ-028 NUM_RST=1 shall release o_rst[0] and enter RUN in the same cycle.

Reset
REQ-029 i_rst=1 at an edge shall set: state=PLL_RST, o_pll_rst=1, o_rst=all 1, o_ready=0, o_lock_lost=0, all counters 0, synchroniser flops 0.
REQ-030 i_rst asserted mid-operation in any state shall override all other transitions.
REQ-031 After i_rst deasserts, the PLL_RST pulse shall be a full PLL_RST_CYCLES long.

Verification (defaults)
REQ-032 Release i_rst with i_locked=0 throughout -> o_pll_rst high for 8 cycles, low for 1024, then high for 8 again, repeating; o_rst stays 4'b1111.
REQ-033 i_locked rises and stays high -> o_rst[0] falls 18 cycles later (+1 sampling tolerance); o_rst[1], [2], [3] fall 4, 8, 12 cycles after that; o_ready rises together with o_rst[3].
REQ-034 i_locked drops for 1 cycle at HOLD count 10 -> FSM returns to WAIT_LOCK; release happens 16 consecutive slock cycles after relock; o_lock_lost stays 0.
REQ-035 In RUN, drop i_locked -> o_rst=4'b1111 and o_ready=0 one cycle after slock falls; o_lock_lost=1; o_pll_rst pulses for 8 cycles.
REQ-036 With CNT_W=2, force 5 lock losses in RUN -> o_lock_lost reads 3 (saturated).
REQ-037 Assert i_rst for 1 cycle during RELEASE -> outputs take their reset values on the next edge, and a full sequence restarts from PLL_RST.
